uart_rate_ctrl: RTL



---
 rtl/uart_rate_ctrl_if.sv | 12 +
 rtl/uart_rate_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_rate_ctrl_if.sv
// Signal bundle between the board UART pin and the rate-control stage.
// The slave side is the receiver; the master side drives the RX line.
interface uart_rate_ctrl_if;
   logic       rx;
   logic [1:0] rate_control;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;

   modport master (output rx, input rate_control, input rx_data, input rx_valid, input frame_err);
   modport slave  (input rx, output rate_control, output rx_data, output rx_valid, output frame_err);
endinterface

// File: rtl/uart_rate_ctrl.sv
// 8N1 UART receiver that decodes single-character ASCII commands into the
// divider's 2-bit rate select, and exposes each good byte with a valid strobe.
module uart_rate_ctrl #(
   parameter int unsigned CLOCKFREQ = 100_000_000,
   parameter int unsigned BAUDRATE  = 115200
) (
   input logic             clk,
   input logic             rst_n,
   uart_rate_ctrl_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = CLOCKFREQ / BAUDRATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = ($clog2(CLKS_PER_BIT) > 10) ? $clog2(CLKS_PER_BIT) : 10;

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, WAIT_HIGH
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [2:0]         bit_cnt, bit_d;
   logic [7:0]         shift, shift_d;
   logic [7:0]         data_q, data_d;
   logic [1:0]         rate_q, rate_d;
   logic               valid_q, valid_d;
   logic               ferr_q, ferr_d;
   logic               rx_meta, rx_s;

   // Next rate select for a command byte; unknown bytes keep the current rate.
   function automatic logic [1:0] decode(input logic [7:0] b, input logic [1:0] cur);
      logic [1:0] r;
      r = cur;
      case (b)
         8'h30: r = 2'b00;
         8'h31: r = 2'b01;
         8'h32: r = 2'b10;
         8'h2B: r = (cur == 2'b00) ? 2'b01 : 2'b10;
         8'h2D: r = (cur == 2'b10) ? 2'b01 : 2'b00;
         default: r = cur;
      endcase
      return r;
   endfunction

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data_q  <= '0;
         rate_q  <= 2'b00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_d;
         shift   <= shift_d;
         data_q  <= data_d;
         rate_q  <= rate_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt + CNT_W'(1);
      bit_d   = bit_cnt;
      shift_d = shift;
      data_d  = data_q;
      rate_d  = rate_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid-start-bit recheck rejects short glitches.
            if (cnt == CNT_W'(HALF_BIT - 1)) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift[7:1]};
               bit_d   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift;
                  valid_d = 1'b1;
                  rate_d  = decode(shift, rate_q);
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not be read as a stream of frames.
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.rate_control = rate_q;
   assign bus.rx_data      = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.frame_err    = ferr_q;

endmodule
